// File: rtl/dma_pkg.sv
// Shared OAM DMA definitions: FSM states, OAM geometry and the FF46 register address.
package dma_pkg;
  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    REQ,
    CAPTURE,
    WRITE,
    PAD
  } dma_state_t;

  localparam int          OAM_BYTES    = 160;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: copies 160 bytes {src_hi,00..9F} into OAM, one byte per slot of >= CYCLES_PER_BYTE clks.
// Optional OAM_DMA_ECHO_REMAP_EN: echo-RAM sources (E0..FF) are read from WRAM (src_hi - 20h).
module oam_dma_controller
  import dma_pkg::*;
#(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int START_DELAY     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_we,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  localparam logic [7:0] CNT_MAX  = 8'(CYCLES_PER_BYTE - 1);
  localparam logic [7:0] DLY_MAX  = 8'(START_DELAY - 1);
  localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

  dma_state_t state_q, state_d;
  logic [7:0] src_q, src_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] dly_q, dly_d;
  logic       oam_we_q;
  logic [7:0] oam_addr_q, oam_wdata_q;
  logic [7:0] rd_hi;

`ifdef OAM_DMA_ECHO_REMAP_EN
  assign rd_hi = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;
`else
  assign rd_hi = src_q;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
    unique case (state_q)
      IDLE: ;
      DELAY: begin
        if (dly_q == DLY_MAX) state_d = REQ;
        else                  dly_d   = dly_q + 8'd1;
      end
      REQ:     if (mem_gnt) state_d = CAPTURE;
      CAPTURE: state_d = WRITE;
      WRITE:   state_d = PAD;
      PAD: begin
        if (cnt_q == CNT_MAX) begin
          idx_d   = idx_q + 8'd1;
          state_d = (idx_q == LAST_IDX) ? IDLE : REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // Slot timing is measured from the first cycle of each request.
    if (state_d == REQ && state_q != REQ) cnt_d = 8'd0;
    // A register write always (re)starts the transfer, overriding any progress.
    if (reg_we) begin
      src_d   = reg_wdata;
      idx_d   = 8'd0;
      dly_d   = 8'd0;
      state_d = DELAY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      src_q       <= 8'hFF;
      idx_q       <= 8'd0;
      cnt_q       <= 8'd0;
      dly_q       <= 8'd0;
      oam_we_q    <= 1'b0;
      oam_addr_q  <= 8'd0;
      oam_wdata_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      dly_q    <= dly_d;
      oam_we_q <= (state_d == WRITE);
      if (state_d == WRITE) begin
        oam_addr_q  <= idx_q;
        oam_wdata_q <= mem_rdata;
      end
    end
  end

  assign reg_rdata  = src_q;
  assign mem_req    = (state_q == REQ);
  assign mem_addr   = mem_req ? {rd_hi, idx_q} : 16'h0000;
  assign oam_we     = oam_we_q;
  assign oam_addr   = oam_addr_q;
  assign oam_wdata  = oam_wdata_q;
  assign dma_active = (state_q != IDLE);

endmodule

// File: tb/tb_oam_dma_controller.sv
// Scoreboard bench for oam_dma_controller: expected reads/writes queued at each FF46 write.
module tb_oam_dma_controller;
  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        reg_we = 1'b0;
  logic [7:0]  reg_wdata = 8'h00;
  logic        mem_gnt = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  reg_rdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        dma_active;

  oam_dma_controller #(.CYCLES_PER_BYTE(CPB), .START_DELAY(4)) dut (
    .clk(clk), .reset(reset), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .oam_we(oam_we),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] a; int c; } req_t;
  typedef struct { logic [7:0] a; logic [7:0] d; int c; } wr_t;

  req_t rq[$];
  wr_t  wq[$];
  int   n_chk = 0, n_err = 0;
  int   cyc = 0, req_age = 0, gnt_wait = 0, wr_cnt = 0, w0 = 0, cur_slot = CPB;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ {a[3:0], a[7:4]} ^ 8'h5A;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (mem_req && mem_gnt) mem_rdata <= pat(mem_addr);

  always @(negedge clk) begin
    req_t r;
    wr_t  w;
    if (mem_req && reset) begin
      mem_gnt = (req_age >= gnt_wait);
      req_age++;
    end else begin
      mem_gnt = 1'b0;
      req_age = 0;
    end
    if (mem_req && mem_gnt) begin
      if (rq.size() == 0) check("req_unexpected", 1, 0);
      else begin
        r = rq.pop_front();
        check("mem_addr", mem_addr, r.a);
        check("gnt_cycle", cyc, r.c);
      end
    end
    if (oam_we) begin
      wr_cnt++;
      if (wq.size() == 0) check("oam_unexpected", 1, 0);
      else begin
        w = wq.pop_front();
        check("oam_addr", oam_addr, w.a);
        check("oam_wdata", oam_wdata, w.d);
        check("oam_cycle", cyc, w.c);
      end
    end
  end

  task automatic start(input logic [7:0] hi, input int gw);
    logic [7:0] eff;
    eff = hi;
`ifdef OAM_DMA_ECHO_REMAP_EN
    if (hi >= 8'hE0) eff = hi - 8'h20;
`endif
    cur_slot = (4 + gw > CPB) ? 4 + gw : CPB;
    rq.delete();
    wq.delete();
    wr_cnt   = 0;
    gnt_wait = gw;
    w0       = cyc;
    for (int n = 0; n < 160; n++) begin
      rq.push_back('{a: {eff, 8'(n)}, c: w0 + 5 + gw + n * cur_slot});
      wq.push_back('{a: 8'(n), d: pat({eff, 8'(n)}), c: w0 + 7 + gw + n * cur_slot});
    end
    reg_wdata = hi;
    reg_we    = 1'b1;
    @(negedge clk); #2;
    reg_we = 1'b0;
    check("active_at_w1", dma_active, 1);
    check("reg_rdata", reg_rdata, hi);
  endtask

  task automatic wait_writes(input int k);
    for (int t = 0; t < 3000 && wr_cnt < k; t++) begin
      @(negedge clk); #2;
    end
    check("writes_reached", wr_cnt, k);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 3000 && dma_active; t++) begin
      @(negedge clk); #2;
    end
    check("dma_fall_cycle", cyc, w0 + 5 + 160 * cur_slot);
    check("write_count", wr_cnt, 160);
    check("wq_empty", wq.size(), 0);
    check("rq_empty", rq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_oam_we", oam_we, 0);
    check("rst_active", dma_active, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_oam_addr", oam_addr, 0);
    check("rst_oam_wdata", oam_wdata, 0);
    check("rst_reg_rdata", reg_rdata, 8'hFF);
    @(negedge clk); #2;
    reset = 1'b1;
    repeat (2) begin @(negedge clk); #2; end

    // Zero-wait grants from C1.
    start(8'hC1, 0);
    wait_done();

    // One extra request cycle per grant stretches each slot to 5.
    start(8'h40, 1);
    wait_done();

    // Restart at byte 50 towards 8000.
    start(8'hC1, 0);
    wait_writes(50);
    start(8'h80, 0);
    wait_done();

    // Asynchronous reset during byte 10.
    start(8'hC1, 0);
    wait_writes(10);
    reset = 1'b0;
    #1;
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_oam_we", oam_we, 0);
    check("mid_rst_active", dma_active, 0);
    check("mid_rst_reg_rdata", reg_rdata, 8'hFF);
    rq.delete();
    wq.delete();
    @(negedge clk); #2;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk); #2;
      check("post_rst_idle", dma_active, 0);
    end

    // Echo source, restarted exactly in the final PAD cycle.
    start(8'hE2, 0);
    for (int t = 0; t < 3000 && cyc < w0 + 644; t++) begin
      @(negedge clk); #2;
    end
    check("final_pad_reached", cyc, w0 + 644);
    check("final_pad_writes", wr_cnt, 160);
    check("final_pad_active", dma_active, 1);
    start(8'hC1, 0);
    repeat (4) begin
      @(negedge clk); #2;
      check("no_idle_gap", dma_active, 1);
    end
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
